// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage definitions: PC generator states and default reset vector / increment.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_2000;
  localparam int          DEF_INCR         = 4;

endpackage

// File: rtl/pc_incr.sv
// Sequential-PC adder: pc + INCR, truncated so the result wraps at PC_WIDTH bits.
module pc_incr #(
  parameter int PC_WIDTH = 32,
  parameter int INCR     = 4
) (
  input  logic [PC_WIDTH-1:0] i_pc,
  output logic [PC_WIDTH-1:0] o_pc_incr
);

  assign o_pc_incr = i_pc + PC_WIDTH'(INCR);

endmodule

// File: rtl/pc_gen_unit.sv
// Registered fetch PC with stall/ready back-pressure, buffered redirects and misaligned-target flagging.
//   state | meaning
//   BOOT  | first cycle after reset, pc_out not yet valid, redirects ignored
//   RUN   | fetching, no redirect waiting
//   PEND  | redirect captured while stalled, applied on the next advance
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR),
  parameter int                  INCR         = DEF_INCR,
  parameter int                  ALIGN_BITS   = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stall,
  input  logic                i_fetch_ready,
  input  logic                i_redirect_valid,
  input  logic [PC_WIDTH-1:0] i_redirect_target,
  output logic [PC_WIDTH-1:0] o_pc_out,
  output logic                o_pc_valid,
  output logic [PC_WIDTH-1:0] o_pc_plus_incr,
  output logic                o_misalign_err
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {PC_WIDTH{1'b1}} << ALIGN_BITS;

  pc_state_e           r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_pc_valid;
  logic [PC_WIDTH-1:0] r_pend;
  logic                r_misalign;

  pc_state_e           w_state_nxt;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic                w_valid_nxt;
  logic [PC_WIDTH-1:0] w_pend_nxt;
  logic                w_mis_nxt;

  logic                w_advance;
  logic [PC_WIDTH-1:0] w_pc_incr;
  logic [PC_WIDTH-1:0] w_tgt_aligned;
  logic                w_tgt_mis;

  pc_incr #(
    .PC_WIDTH (PC_WIDTH),
    .INCR     (INCR)
  ) u_pc_incr (
    .i_pc      (r_pc),
    .o_pc_incr (w_pc_incr)
  );

  assign w_advance     = r_pc_valid & i_fetch_ready & ~i_stall;
  assign w_tgt_aligned = i_redirect_target & ALIGN_MASK;
  assign w_tgt_mis     = |(i_redirect_target & ~ALIGN_MASK);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_pc_valid;
    w_pend_nxt  = r_pend;
    w_mis_nxt   = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
        w_valid_nxt = 1'b1;
      end
      RUN, PEND: begin
        // A live redirect always beats the buffered one (youngest wins).
        if (i_redirect_valid) begin
          w_mis_nxt = w_tgt_mis;
          if (w_advance) begin
            w_pc_nxt    = w_tgt_aligned;
            w_pend_nxt  = '0;
            w_state_nxt = RUN;
          end else begin
            w_pend_nxt  = w_tgt_aligned;
            w_state_nxt = PEND;
          end
        end else if (w_advance) begin
          if (r_state == PEND) begin
            w_pc_nxt    = r_pend;
            w_pend_nxt  = '0;
            w_state_nxt = RUN;
          end else begin
            w_pc_nxt = w_pc_incr;
          end
        end
      end
      default: begin
        w_state_nxt = BOOT;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_pend     <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pc_valid <= w_valid_nxt;
      r_pend     <= w_pend_nxt;
      r_misalign <= w_mis_nxt;
    end
  end

  assign o_pc_out       = r_pc;
  assign o_pc_valid     = r_pc_valid;
  assign o_pc_plus_incr = w_pc_incr;
  assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit with default parameters.
module tb_pc_gen_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] pc_plus_incr;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen_unit dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_fetch_ready     (fetch_ready),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .o_pc_out          (pc_out),
    .o_pc_valid        (pc_valid),
    .o_pc_plus_incr    (pc_plus_incr),
    .o_misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    for (int i = 0; i < 3; i++) step();
    n_checks++; if (pc_out !== 32'h2000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h2000); end
    n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_mis got=%b exp=0", misalign_err); end
    rst = 1'b0;
    #1;
    n_checks++; if (pc_out !== 32'h2000 || pc_valid !== 1'b0) begin n_fail++; $display("FAIL boot_c0 got=%h/%b exp=00002000/0", pc_out, pc_valid); end
  endtask

  task automatic test_boot_seq();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h2000; exp_pc[1] = 32'h2004; exp_pc[2] = 32'h2008; exp_pc[3] = 32'h200C;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pc_out !== exp_pc[i] || pc_valid !== 1'b1) begin n_fail++; $display("FAIL boot_seq[%0d] got=%h/%b exp=%h/1", i, pc_out, pc_valid, exp_pc[i]); end
      n_checks++; if (pc_plus_incr !== exp_pc[i] + 32'd4) begin n_fail++; $display("FAIL plus_incr[%0d] got=%h exp=%h", i, pc_plus_incr, exp_pc[i] + 32'd4); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (pc_out !== 32'h2008) begin n_fail++; $display("FAIL stall_hold[%0d] got=%h exp=00002008", i, pc_out); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (pc_out !== 32'h200C) begin n_fail++; $display("FAIL stall_release got=%h exp=0000200c", pc_out); end
    fetch_ready = 1'b0;
    step();
    n_checks++; if (pc_out !== 32'h200C) begin n_fail++; $display("FAIL not_ready_hold got=%h exp=0000200c", pc_out); end
    fetch_ready = 1'b1;
    step();
    n_checks++; if (pc_out !== 32'h2010) begin n_fail++; $display("FAIL ready_release got=%h exp=00002010", pc_out); end
  endtask

  task automatic test_redirect_advance();
    redirect_valid = 1'b1; redirect_target = 32'h3000;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc_out !== 32'h3000) begin n_fail++; $display("FAIL redir_adv got=%h exp=00003000", pc_out); end
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL redir_adv_mis got=%b exp=0", misalign_err); end
    step();
    n_checks++; if (pc_out !== 32'h3004) begin n_fail++; $display("FAIL redir_adv_next got=%h exp=00003004", pc_out); end
  endtask

  task automatic test_pending();
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h4000;
    step();
    redirect_valid = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_target = 32'h5000;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc_out !== 32'h3004) begin n_fail++; $display("FAIL pend_hold got=%h exp=00003004", pc_out); end
    step();
    n_checks++; if (pc_out !== 32'h3004) begin n_fail++; $display("FAIL pend_hold2 got=%h exp=00003004", pc_out); end
    stall = 1'b0;
    step();
    n_checks++; if (pc_out !== 32'h5000) begin n_fail++; $display("FAIL pend_apply got=%h exp=00005000", pc_out); end
    step();
    n_checks++; if (pc_out !== 32'h5004) begin n_fail++; $display("FAIL pend_next got=%h exp=00005004", pc_out); end
  endtask

  task automatic test_misalign_wrap();
    redirect_valid = 1'b1; redirect_target = 32'h3003;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc_out !== 32'h3000 || misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_apply got=%h/%b exp=00003000/1", pc_out, misalign_err); end
    step();
    n_checks++; if (pc_out !== 32'h3004 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end got=%h/%b exp=00003004/0", pc_out, misalign_err); end
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h3102;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc_out !== 32'h3004 || misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_capture got=%h/%b exp=00003004/1", pc_out, misalign_err); end
    step();
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_capture_end got=%b exp=0", misalign_err); end
    stall = 1'b0;
    step();
    n_checks++; if (pc_out !== 32'h3100) begin n_fail++; $display("FAIL mis_pend_apply got=%h exp=00003100", pc_out); end
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_tgt got=%h exp=fffffffc", pc_out); end
    n_checks++; if (pc_plus_incr !== 32'h0) begin n_fail++; $display("FAIL wrap_plus got=%h exp=00000000", pc_plus_incr); end
    step();
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=00000000", pc_out); end
  endtask

  task automatic test_async_reset_pend();
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h6000;
    step();
    redirect_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (pc_out !== 32'h2000 || pc_valid !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL async_rst got=%h/%b/%b exp=00002000/0/0", pc_out, pc_valid, misalign_err); end
    step();
    rst = 1'b0; stall = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h7000;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc_out !== 32'h2000 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL reboot got=%h/%b exp=00002000/1", pc_out, pc_valid); end
    step();
    n_checks++; if (pc_out !== 32'h2004) begin n_fail++; $display("FAIL reboot_next got=%h exp=00002004", pc_out); end
  endtask

  initial begin
    test_reset();
    test_boot_seq();
    test_stall();
    test_redirect_advance();
    test_pending();
    test_misalign_wrap();
    test_async_reset_pend();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
